bus_mem_responder: RTL and testbench

//  Memory-side responder for the cache's request/response bus. Accepts line-read and

---
 rtl/bus_mem_responder.sv | 94 +++++++++
 tb/tb_bus_mem_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mem_responder.sv
// bus_mem_responder: memory-side responder that serves cache line reads and absorbs
// line writes as BEATS-word bursts over the request/response bus.
module bus_mem_responder #(
    parameter int DATA_WIDTH   = 64,
    parameter int TAG_WIDTH    = 13,
    parameter int BEATS        = 8,
    parameter int MEM_WORDS    = 4096,
    parameter int READ_LATENCY = 4,
    parameter int TAG_READ     = 1,
    parameter int TAG_WRITE    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bus_reqcyc,
    output logic                  bus_reqack,
    input  logic [DATA_WIDTH-1:0] bus_req,
    input  logic [TAG_WIDTH-1:0]  bus_reqtag,
    output logic                  bus_respcyc,
    input  logic                  bus_respack,
    output logic [DATA_WIDTH-1:0] bus_resp,
    output logic [TAG_WIDTH-1:0]  bus_resptag,
    output logic                  busy,
    output logic                  bad_tag
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int CW = READ_LATENCY > 1 ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_SEND, RD_GAP, WR_DATA, WR_RESP} state_t;

    state_t                state, state_n;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         beat;
    logic [DATA_WIDTH-1:0] line_base, rd_data;
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic [AW-1:0]         idx;
    logic                  accept, is_read, is_write, last_beat;

    assign accept    = bus_reqcyc && !bus_reqack && (state == IDLE || state == WR_DATA);
    assign is_read   = bus_reqtag == TAG_WIDTH'(TAG_READ);
    assign is_write  = bus_reqtag == TAG_WIDTH'(TAG_WRITE);
    assign last_beat = beat == BW'(BEATS - 1);
    assign idx       = line_base[AW+2:3] + AW'(beat);

    assign busy        = state != IDLE;
    assign bus_respcyc = state == RD_SEND || state == WR_RESP;
    assign bus_resp    = state == RD_SEND ? rd_data : state == WR_RESP ? line_base : '0;
    assign bus_resptag = state == RD_SEND ? TAG_WIDTH'(TAG_READ) :
                         state == WR_RESP ? TAG_WIDTH'(TAG_WRITE) : '0;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = is_read ? RD_WAIT : is_write ? WR_DATA : IDLE;
            RD_WAIT: if (cnt == '0) state_n = RD_SEND;
            RD_SEND: if (bus_respack) state_n = last_beat ? IDLE : RD_GAP;
            RD_GAP:  state_n = RD_SEND;
            WR_DATA: if (accept && last_beat) state_n = WR_RESP;
            WR_RESP: if (bus_respack) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            beat       <= '0;
            line_base  <= '0;
            bus_reqack <= 1'b0;
            bad_tag    <= 1'b0;
        end else begin
            state      <= state_n;
            bus_reqack <= accept;
            bad_tag    <= accept && state == IDLE && !is_read && !is_write;
            if (accept && state == IDLE) begin
                line_base <= {bus_req[DATA_WIDTH-1:6], 6'd0};
                cnt       <= CW'(READ_LATENCY - 1);
                beat      <= '0;
            end
            if (state == RD_WAIT && cnt != '0)
                cnt <= cnt - 1'b1;
            if ((state == RD_SEND && bus_respack) || (state == WR_DATA && accept))
                beat <= beat + 1'b1;
        end
    end

    // Synchronous read: idx already points at the next beat when RD_SEND is entered.
    always_ff @(posedge clk) begin
        if (reset && state == WR_DATA && accept)
            mem[idx] <= bus_req;
        rd_data <= mem[idx];
    end
endmodule

// File: tb/tb_bus_mem_responder.sv
// tb_bus_mem_responder: scoreboard bench for the line read/write responder.
module tb_bus_mem_responder;
    logic        clk = 1'b0, reset = 1'b0, bus_reqcyc = 1'b0, bus_respack = 1'b0;
    logic [63:0] bus_req = '0;
    logic [12:0] bus_reqtag = '0;
    logic        bus_reqack, bus_respcyc, busy, bad_tag;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;

    typedef struct packed { logic [63:0] data; logic [12:0] tag; } beat_t;
    beat_t exp_q[$];
    beat_t mon_e;
    int passed = 0, total = 0;

    bus_mem_responder dut (
        .clk(clk), .reset(reset),
        .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack),
        .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_respcyc(bus_respcyc), .bus_respack(bus_respack),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag),
        .busy(busy), .bad_tag(bad_tag)
    );

    always #5 clk = ~clk;

    // A beat is consumed at the next posedge when respcyc and respack are both high.
    always @(negedge clk) begin
        if (reset && bus_respcyc && bus_respack) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL resp_unexpected got %h tag %0d, want no beat", bus_resp, bus_resptag);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus_resp !== mon_e.data || bus_resptag !== mon_e.tag)
                    $display("FAIL resp_beat got %h tag %0d, want %h tag %0d",
                             bus_resp, bus_resptag, mon_e.data, mon_e.tag);
                else
                    passed++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input logic [12:0] t);
        int n = 0;
        bus_req = d;
        bus_reqtag = t;
        bus_reqcyc = 1'b1;
        do begin tick(); n++; end while (!bus_reqack && n < 40);
        bus_reqcyc = 1'b0;
        if (!bus_reqack) begin
            total++;
            $display("FAIL req_ack_timeout got no reqack, want reqack for %h", d);
        end
    endtask

    task automatic wait_resp();
        int n = 0;
        while (!bus_respcyc && n < 40) begin tick(); n++; end
        if (!bus_respcyc) begin
            total++;
            $display("FAIL resp_timeout got respcyc 0, want 1");
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin tick(); n++; end
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL drain_timeout got %0d beats pending, want 0", exp_q.size());
        end
    endtask

    task automatic push_line(input logic [63:0] first, input logic [12:0] t);
        for (int i = 0; i < 8; i++) exp_q.push_back({first + 64'(i), t});
    endtask

    task automatic write_line(input logic [63:0] addr, input logic [63:0] first);
        exp_q.push_back({addr & ~64'h3F, 13'd2});
        send(addr, 13'd2);
        for (int i = 0; i < 8; i++) send(first + 64'(i), 13'd5);
        bus_respack = 1'b1;
        drain();
        bus_respack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus_reqcyc = 1'b1;
        bus_reqtag = 13'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({bus_reqack, bus_respcyc, busy, bad_tag} !== 4'b0 || bus_resp !== 64'd0)
                $display("FAIL reset_outputs got ack %b cyc %b busy %b bad %b resp %h, want all 0",
                         bus_reqack, bus_respcyc, busy, bad_tag, bus_resp);
            else passed++;
        end
        reset = 1'b1;
        tick();
        total++;
        if (bus_reqack !== 1'b1 || bad_tag !== 1'b1)
            $display("FAIL reset_release_accept got ack %b bad %b, want 1 1", bus_reqack, bad_tag);
        else passed++;
        bus_reqcyc = 1'b0;
        tick();
        total++;
        if (bus_reqack !== 1'b0 || bad_tag !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_release_after got ack %b bad %b busy %b, want 0 0 0",
                     bus_reqack, bad_tag, busy);
        else passed++;
    endtask

    task automatic test_read_latency();
        int n;
        write_line(64'h40, 64'h100);
        push_line(64'h100, 13'd1);
        bus_respack = 1'b1;
        send(64'h47, 13'd1);
        tick();
        total++;
        if (bus_reqack !== 1'b0 || busy !== 1'b1)
            $display("FAIL read_ack_pulse got ack %b busy %b, want 0 1", bus_reqack, busy);
        else passed++;
        n = 1;
        while (!bus_respcyc && n < 20) begin tick(); n++; end
        total++;
        if (n !== 4) $display("FAIL read_latency got %0d cycles, want 4", n);
        else passed++;
        drain();
        total++;
        if (busy !== 1'b0) $display("FAIL read_done_busy got %b, want 0", busy);
        else passed++;
        bus_respack = 1'b0;
    endtask

    task automatic test_write_read();
        write_line(64'h9F, 64'hA0);
        push_line(64'hA0, 13'd1);
        bus_respack = 1'b1;
        send(64'h80, 13'd1);
        drain();
        bus_respack = 1'b0;
        total++;
        if (busy !== 1'b0) $display("FAIL write_read_busy got %b, want 0", busy);
        else passed++;
    endtask

    task automatic test_stall();
        push_line(64'hA0, 13'd1);
        send(64'h80, 13'd1);
        for (int k = 0; k < 8; k++) begin
            wait_resp();
            if (k == 3) begin
                for (int s = 0; s < 5; s++) begin
                    total++;
                    if (bus_respcyc !== 1'b1 || bus_resp !== 64'hA3)
                        $display("FAIL stall_hold got cyc %b resp %h, want 1 a3", bus_respcyc, bus_resp);
                    else passed++;
                    tick();
                end
            end
            bus_respack = 1'b1;
            tick();
            bus_respack = 1'b0;
            if (k == 3) begin
                total++;
                if (bus_respcyc !== 1'b0) $display("FAIL stall_gap got cyc %b, want 0", bus_respcyc);
                else passed++;
                tick();
                total++;
                if (bus_respcyc !== 1'b1 || bus_resp !== 64'hA4)
                    $display("FAIL stall_next got cyc %b resp %h, want 1 a4", bus_respcyc, bus_resp);
                else passed++;
            end
        end
        total++;
        if (busy !== 1'b0 || exp_q.size() != 0)
            $display("FAIL stall_done got busy %b pending %0d, want 0 0", busy, exp_q.size());
        else passed++;
    endtask

    task automatic test_bad_tag();
        bus_respack = 1'b1;
        send(64'h200, 13'd7);
        total++;
        if (bad_tag !== 1'b1 || busy !== 1'b0)
            $display("FAIL bad_tag_pulse got bad %b busy %b, want 1 0", bad_tag, busy);
        else passed++;
        tick();
        total++;
        if (bad_tag !== 1'b0 || bus_reqack !== 1'b0)
            $display("FAIL bad_tag_clear got bad %b ack %b, want 0 0", bad_tag, bus_reqack);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (bus_respcyc !== 1'b0 || busy !== 1'b0)
                $display("FAIL bad_tag_quiet got cyc %b busy %b, want 0 0", bus_respcyc, busy);
            else passed++;
            tick();
        end
        bus_respack = 1'b0;
    endtask

    task automatic test_reset_mid();
        push_line(64'h100, 13'd1);
        send(64'h40, 13'd1);
        for (int k = 0; k < 2; k++) begin
            wait_resp();
            bus_respack = 1'b1;
            tick();
            bus_respack = 1'b0;
        end
        wait_resp();
        total++;
        if (bus_resp !== 64'h102) $display("FAIL mid_beat2 got %h, want 102", bus_resp);
        else passed++;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_q.delete();
        total++;
        if (busy !== 1'b0 || bus_respcyc !== 1'b0 || bus_resp !== 64'd0)
            $display("FAIL mid_reset got busy %b cyc %b resp %h, want 0 0 0", busy, bus_respcyc, bus_resp);
        else passed++;
        bus_respack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (bus_respcyc !== 1'b0) $display("FAIL mid_quiet got cyc %b, want 0", bus_respcyc);
            else passed++;
            tick();
        end
        push_line(64'hA0, 13'd1);
        send(64'h80, 13'd1);
        drain();
        bus_respack = 1'b0;
        total++;
        if (busy !== 1'b0) $display("FAIL mid_fresh_busy got %b, want 0", busy);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_write_read();
        test_stall();
        test_bad_tag();
        test_reset_mid();
        repeat (3) tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
